// File: rtl/ica_iter_ctrl.sv
// ica_iter_ctrl: iteration controller for the ICA weight-refinement loop.
//
// Sequences one run: load the initial 4x4 weight matrix into the w_ica
// register, then repeatedly request a weight update, request a convergence
// check, and either stop or adopt the returned weights and iterate again.
//
// Ports
//   clk_iter, rst_n         : clock, asynchronous active-low reset
//   start                   : run request, honoured only when idle
//   w_init11..w_init44      : signed initial weight matrix
//   en_update / update_busy : one-cycle request and busy flag, update engine
//   w_ica11..w_ica44        : signed previous-iteration weights to error block
//   en_error / error_busy   : one-cycle request and busy flag, error block
//   w11..w44, isConverge    : weights and convergence verdict from error block
//   iter_count              : completed iterations (saturates at 255)
//   busy, done, converged, fault : run status flags
module ica_iter_ctrl #(
    parameter int MAX_ITER     = 100,
    parameter int BUSY_TIMEOUT = 255,
    parameter int DATA_W       = 26
) (
    input  logic                     clk_iter,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic signed [DATA_W-1:0] w_init11, w_init12, w_init13, w_init14,
    input  logic signed [DATA_W-1:0] w_init21, w_init22, w_init23, w_init24,
    input  logic signed [DATA_W-1:0] w_init31, w_init32, w_init33, w_init34,
    input  logic signed [DATA_W-1:0] w_init41, w_init42, w_init43, w_init44,
    output logic                     en_update,
    input  logic                     update_busy,
    output logic signed [DATA_W-1:0] w_ica11, w_ica12, w_ica13, w_ica14,
    output logic signed [DATA_W-1:0] w_ica21, w_ica22, w_ica23, w_ica24,
    output logic signed [DATA_W-1:0] w_ica31, w_ica32, w_ica33, w_ica34,
    output logic signed [DATA_W-1:0] w_ica41, w_ica42, w_ica43, w_ica44,
    output logic                     en_error,
    input  logic                     error_busy,
    input  logic signed [DATA_W-1:0] w11, w12, w13, w14,
    input  logic signed [DATA_W-1:0] w21, w22, w23, w24,
    input  logic signed [DATA_W-1:0] w31, w32, w33, w34,
    input  logic signed [DATA_W-1:0] w41, w42, w43, w44,
    input  logic                     isConverge,
    output logic [7:0]               iter_count,
    output logic                     busy,
    output logic                     done,
    output logic                     converged,
    output logic                     fault
);

    // The counter only ever holds 0..BUSY_TIMEOUT-1; hitting the last value
    // while still waiting is the timeout.
    localparam int TMO_W = (BUSY_TIMEOUT > 1) ? $clog2(BUSY_TIMEOUT) : 1;
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(BUSY_TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_UPD_REQ, S_UPD_WAIT,
        S_ERR_REQ, S_ERR_WAIT, S_CHECK, S_HALT
    } state_t;

    state_t                   state_q, state_d;
    logic [TMO_W-1:0]         tmo_q, tmo_d;
    logic                     seen_q, seen_d;
    logic                     done_q, done_d;
    logic                     conv_q, conv_d;
    logic                     fault_q, fault_d;
    logic [7:0]               iter_q, iter_d;
    logic [8:0]               iter_plus1;
    logic                     load_init, load_ret;

    logic signed [DATA_W-1:0] w_init_a [16];
    logic signed [DATA_W-1:0] w_ret_a  [16];
    logic signed [DATA_W-1:0] w_ica_q  [16];
    logic signed [DATA_W-1:0] w_ica_d  [16];

    assign w_init_a = '{w_init11, w_init12, w_init13, w_init14,
                        w_init21, w_init22, w_init23, w_init24,
                        w_init31, w_init32, w_init33, w_init34,
                        w_init41, w_init42, w_init43, w_init44};
    assign w_ret_a  = '{w11, w12, w13, w14, w21, w22, w23, w24,
                        w31, w32, w33, w34, w41, w42, w43, w44};

    assign iter_plus1 = {1'b0, iter_q} + 9'd1;

    always_comb begin
        state_d   = state_q;
        tmo_d     = tmo_q;
        seen_d    = seen_q;
        done_d    = done_q;
        conv_d    = conv_q;
        fault_d   = fault_q;
        iter_d    = iter_q;
        load_init = 1'b0;
        load_ret  = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    done_d  = 1'b0;
                    conv_d  = 1'b0;
                    fault_d = 1'b0;
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                load_init = 1'b1;
                iter_d    = 8'd0;
                state_d   = S_UPD_REQ;
            end
            // Busy already high during the request cycle counts as seen.
            S_UPD_REQ: begin
                tmo_d   = '0;
                seen_d  = update_busy;
                state_d = S_UPD_WAIT;
            end
            S_UPD_WAIT: begin
                if (seen_q && !update_busy) begin
                    state_d = S_ERR_REQ;
                end else if (tmo_q == TMO_LAST) begin
                    fault_d = 1'b1;
                    done_d  = 1'b1;
                    conv_d  = 1'b0;
                    state_d = S_HALT;
                end else begin
                    tmo_d  = tmo_q + TMO_W'(1);
                    seen_d = seen_q | update_busy;
                end
            end
            S_ERR_REQ: begin
                tmo_d   = '0;
                seen_d  = error_busy;
                state_d = S_ERR_WAIT;
            end
            S_ERR_WAIT: begin
                if (seen_q && !error_busy) begin
                    state_d = S_CHECK;
                end else if (tmo_q == TMO_LAST) begin
                    fault_d = 1'b1;
                    done_d  = 1'b1;
                    conv_d  = 1'b0;
                    state_d = S_HALT;
                end else begin
                    tmo_d  = tmo_q + TMO_W'(1);
                    seen_d = seen_q | error_busy;
                end
            end
            S_CHECK: begin
                if (isConverge) begin
                    conv_d  = 1'b1;
                    done_d  = 1'b1;
                    state_d = S_HALT;
                end else if (iter_plus1 == 9'(MAX_ITER)) begin
                    iter_d  = 8'(MAX_ITER);
                    conv_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = S_HALT;
                end else begin
                    load_ret = 1'b1;
                    iter_d   = (iter_q == 8'hFF) ? iter_q : iter_plus1[7:0];
                    state_d  = S_UPD_REQ;
                end
            end
            S_HALT: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        for (int i = 0; i < 16; i++) begin
            w_ica_d[i] = w_ica_q[i];
            if (load_init) begin
                w_ica_d[i] = w_init_a[i];
            end else if (load_ret) begin
                w_ica_d[i] = w_ret_a[i];
            end
        end
    end

    always_ff @(posedge clk_iter or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            tmo_q   <= '0;
            seen_q  <= 1'b0;
            done_q  <= 1'b0;
            conv_q  <= 1'b0;
            fault_q <= 1'b0;
            iter_q  <= 8'd0;
            for (int i = 0; i < 16; i++) begin
                w_ica_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            tmo_q   <= tmo_d;
            seen_q  <= seen_d;
            done_q  <= done_d;
            conv_q  <= conv_d;
            fault_q <= fault_d;
            iter_q  <= iter_d;
            for (int i = 0; i < 16; i++) begin
                w_ica_q[i] <= w_ica_d[i];
            end
        end
    end

    // Requests and busy decode straight from the state so reset clears them
    // at once.
    assign en_update  = (state_q == S_UPD_REQ);
    assign en_error   = (state_q == S_ERR_REQ);
    assign busy       = (state_q != S_IDLE) && (state_q != S_HALT);
    assign done       = done_q;
    assign converged  = conv_q;
    assign fault      = fault_q;
    assign iter_count = iter_q;

    assign w_ica11 = w_ica_q[0];
    assign w_ica12 = w_ica_q[1];
    assign w_ica13 = w_ica_q[2];
    assign w_ica14 = w_ica_q[3];
    assign w_ica21 = w_ica_q[4];
    assign w_ica22 = w_ica_q[5];
    assign w_ica23 = w_ica_q[6];
    assign w_ica24 = w_ica_q[7];
    assign w_ica31 = w_ica_q[8];
    assign w_ica32 = w_ica_q[9];
    assign w_ica33 = w_ica_q[10];
    assign w_ica34 = w_ica_q[11];
    assign w_ica41 = w_ica_q[12];
    assign w_ica42 = w_ica_q[13];
    assign w_ica43 = w_ica_q[14];
    assign w_ica44 = w_ica_q[15];

endmodule

// File: tb/tb_ica_iter_ctrl.sv
// Testbench for ica_iter_ctrl: behavioural engines for the update and error
// blocks, and a run-level reference model predicting the outcome of each run.
module tb_ica_iter_ctrl;

    localparam int MAX_ITER     = 3;
    localparam int BUSY_TIMEOUT = 10;

    logic clk_iter = 1'b0;
    always #5 clk_iter = ~clk_iter;

    logic              rst_n, start, update_busy, error_busy, isConverge;
    logic              en_update, en_error, busy, done, converged, fault;
    logic [7:0]        iter_count;
    logic signed [25:0] w_init [16];
    logic signed [25:0] w_ret  [16];
    logic signed [25:0] w_ica  [16];

    ica_iter_ctrl #(.MAX_ITER(MAX_ITER), .BUSY_TIMEOUT(BUSY_TIMEOUT)) dut (
        .clk_iter(clk_iter), .rst_n(rst_n), .start(start),
        .w_init11(w_init[0]),  .w_init12(w_init[1]),  .w_init13(w_init[2]),  .w_init14(w_init[3]),
        .w_init21(w_init[4]),  .w_init22(w_init[5]),  .w_init23(w_init[6]),  .w_init24(w_init[7]),
        .w_init31(w_init[8]),  .w_init32(w_init[9]),  .w_init33(w_init[10]), .w_init34(w_init[11]),
        .w_init41(w_init[12]), .w_init42(w_init[13]), .w_init43(w_init[14]), .w_init44(w_init[15]),
        .en_update(en_update), .update_busy(update_busy),
        .w_ica11(w_ica[0]),  .w_ica12(w_ica[1]),  .w_ica13(w_ica[2]),  .w_ica14(w_ica[3]),
        .w_ica21(w_ica[4]),  .w_ica22(w_ica[5]),  .w_ica23(w_ica[6]),  .w_ica24(w_ica[7]),
        .w_ica31(w_ica[8]),  .w_ica32(w_ica[9]),  .w_ica33(w_ica[10]), .w_ica34(w_ica[11]),
        .w_ica41(w_ica[12]), .w_ica42(w_ica[13]), .w_ica43(w_ica[14]), .w_ica44(w_ica[15]),
        .en_error(en_error), .error_busy(error_busy),
        .w11(w_ret[0]),  .w12(w_ret[1]),  .w13(w_ret[2]),  .w14(w_ret[3]),
        .w21(w_ret[4]),  .w22(w_ret[5]),  .w23(w_ret[6]),  .w24(w_ret[7]),
        .w31(w_ret[8]),  .w32(w_ret[9]),  .w33(w_ret[10]), .w34(w_ret[11]),
        .w41(w_ret[12]), .w42(w_ret[13]), .w43(w_ret[14]), .w44(w_ret[15]),
        .isConverge(isConverge), .iter_count(iter_count),
        .busy(busy), .done(done), .converged(converged), .fault(fault)
    );

    int total = 0;
    int bad   = 0;

    task automatic check_eq(input string tag, input logic signed [63:0] got,
                            input logic signed [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Engine behaviour and run plan
    bit  lat_rand, err_never, start_noise;
    int  fix_dly, fix_len;
    bit  upd_act, err_act;
    int  upd_dly, upd_len, err_dly, err_len;
    bit  conv_plan [8];
    logic signed [25:0] wplan [8][16];
    int  upd_pulses, err_pulses, cyc;

    // One clock: sample at the falling edge, then drive engine inputs.
    task automatic tick();
        int k;
        @(negedge clk_iter);
        cyc++;
        if (en_update === 1'b1) begin
            upd_pulses++;
            upd_act = 1'b1;
            upd_dly = lat_rand ? int'($urandom_range(0, 2)) : fix_dly;
            upd_len = lat_rand ? int'($urandom_range(1, 3)) : fix_len;
        end
        if (en_error === 1'b1) begin
            err_pulses++;
            err_act = !err_never;
            err_dly = lat_rand ? int'($urandom_range(0, 2)) : fix_dly;
            err_len = lat_rand ? int'($urandom_range(1, 3)) : fix_len;
            k = (err_pulses > 8) ? 7 : err_pulses - 1;
            isConverge = conv_plan[k];
            for (int i = 0; i < 16; i++) w_ret[i] = wplan[k][i];
        end
        if (upd_act) begin
            if (upd_dly > 0) begin upd_dly--; update_busy = 1'b0; end
            else if (upd_len > 0) begin update_busy = 1'b1; upd_len--; end
            else begin update_busy = 1'b0; upd_act = 1'b0; end
        end
        if (err_act) begin
            if (err_dly > 0) begin err_dly--; error_busy = 1'b0; end
            else if (err_len > 0) begin error_busy = 1'b1; err_len--; end
            else begin error_busy = 1'b0; err_act = 1'b0; end
        end
        // Verdict is only meaningful in the check; scramble it elsewhere.
        if (upd_act) isConverge = 1'($urandom_range(0, 1));
        if (start_noise && busy === 1'b1) start = 1'($urandom_range(0, 1));
    endtask

    task automatic clear_engines();
        upd_act = 1'b0; err_act = 1'b0;
        update_busy = 1'b0; error_busy = 1'b0;
    endtask

    task automatic rand_plan();
        for (int i = 0; i < 16; i++) w_init[i] = 26'($urandom);
        for (int k = 0; k < 8; k++)
            for (int i = 0; i < 16; i++) wplan[k][i] = 26'($urandom);
    endtask

    // A full run from IDLE; conv_at is the first check index reporting
    // convergence (out of range means never). Ends at the IDLE cycle after HALT.
    task automatic run_case(input string nm, input int conv_at, input bit hold);
        int checks, exp_iter, n;
        bit exp_conv;
        logic signed [25:0] exp_w [16];
        for (int k = 0; k < 8; k++) conv_plan[k] = (k == conv_at);
        exp_conv = 1'b0;
        exp_iter = 0;
        checks   = 0;
        for (int k = 0; k < 8; k++) begin
            checks = k + 1;
            if (k == conv_at) begin exp_conv = 1'b1; exp_iter = k; break; end
            if (k + 1 == MAX_ITER) begin exp_conv = 1'b0; exp_iter = MAX_ITER; break; end
        end
        for (int i = 0; i < 16; i++) exp_w[i] = (checks == 1) ? w_init[i] : wplan[checks-2][i];

        upd_pulses = 0;
        err_pulses = 0;
        start = 1'b1;
        tick();
        if (!hold) start = 1'b0;
        check_eq({nm, ".load_busy"}, busy, 1);
        check_eq({nm, ".done_cleared"}, done, 0);
        n = 0;
        while (done !== 1'b1 && n < 200) begin tick(); n++; end
        start = hold;
        check_eq({nm, ".halt_reached"}, (n < 200), 1);
        check_eq({nm, ".converged"}, converged, exp_conv);
        check_eq({nm, ".fault"}, fault, 0);
        check_eq({nm, ".iter_count"}, iter_count, exp_iter);
        check_eq({nm, ".upd_pulses"}, upd_pulses, checks);
        check_eq({nm, ".err_pulses"}, err_pulses, checks);
        check_eq({nm, ".halt_busy"}, busy, 0);
        for (int i = 0; i < 16; i++)
            check_eq($sformatf("%s.w_ica[%0d]", nm, i), w_ica[i], exp_w[i]);
        tick();
        check_eq({nm, ".idle_busy"}, busy, 0);
        check_eq({nm, ".idle_done"}, done, 1);
        check_eq({nm, ".idle_iter"}, iter_count, exp_iter);
        check_eq({nm, ".idle_conv"}, converged, exp_conv);
    endtask

    initial begin
        int n, c0, c1;
        cyc = 0;
        lat_rand = 1'b0; err_never = 1'b0; start_noise = 1'b0;
        fix_dly = 1; fix_len = 3;
        rst_n = 1'b0; start = 1'b0; isConverge = 1'b0;
        clear_engines();
        for (int i = 0; i < 16; i++) begin w_init[i] = '0; w_ret[i] = '0; end
        for (int k = 0; k < 8; k++) begin
            conv_plan[k] = 1'b0;
            for (int i = 0; i < 16; i++) wplan[k][i] = '0;
        end
        #1;
        check_eq("rst.busy", busy, 0);
        check_eq("rst.done", done, 0);
        check_eq("rst.iter", iter_count, 0);
        check_eq("rst.en_update", en_update, 0);
        check_eq("rst.w_ica11", w_ica[0], 0);
        tick(); tick();
        rst_n = 1'b1;
        tick();

        // Single-iteration convergence, engines busy for 3 cycles.
        w_init[0] = 26'sd1000;
        run_case("conv_first", 0, 0);

        // Two non-converged checks, returned w11 = 5, 6, 7.
        for (int k = 0; k < 3; k++) wplan[k][0] = 26'(5 + k);
        run_case("conv_third", 2, 0);

        // Never converges: stops on the iteration limit.
        rand_plan();
        run_case("max_iter", -1, 0);

        // Error block never responds. The en_error cycle is followed by
        // BUSY_TIMEOUT waiting cycles; fault shows in the cycle after that.
        err_never = 1'b1;
        upd_pulses = 0; err_pulses = 0;
        start = 1'b1; tick(); start = 1'b0;
        n = 0;
        while (err_pulses == 0 && n < 100) begin tick(); n++; end
        c0 = cyc;
        n = 0;
        while (fault !== 1'b1 && n < 100) begin tick(); n++; end
        c1 = cyc;
        check_eq("tmo.reached", (n < 100), 1);
        check_eq("tmo.cycles", c1 - c0, BUSY_TIMEOUT + 1);
        check_eq("tmo.done", done, 1);
        check_eq("tmo.converged", converged, 0);
        check_eq("tmo.iter", iter_count, 0);
        tick(); tick(); tick();
        check_eq("tmo.upd_pulses", upd_pulses, 1);
        check_eq("tmo.idle_fault", fault, 1);
        check_eq("tmo.idle_busy", busy, 0);
        err_never = 1'b0;
        clear_engines();

        // Reset in the update wait of iteration 1.
        rand_plan();
        wplan[0][0] = 26'sd777;
        for (int k = 0; k < 8; k++) conv_plan[k] = 1'b0;
        fix_dly = 0; fix_len = 3;
        upd_pulses = 0; err_pulses = 0;
        start = 1'b1; tick(); start = 1'b0;
        n = 0;
        while (upd_pulses < 2 && n < 100) begin tick(); n++; end
        tick();
        check_eq("rstmid.pre_busy", busy, 1);
        check_eq("rstmid.pre_iter", iter_count, 1);
        check_eq("rstmid.pre_w", w_ica[0], 777);
        #2 rst_n = 1'b0;
        #1;
        check_eq("rstmid.busy", busy, 0);
        check_eq("rstmid.en_update", en_update, 0);
        check_eq("rstmid.en_error", en_error, 0);
        check_eq("rstmid.iter", iter_count, 0);
        check_eq("rstmid.done", done, 0);
        check_eq("rstmid.conv", converged, 0);
        check_eq("rstmid.fault", fault, 0);
        check_eq("rstmid.w11", w_ica[0], 0);
        clear_engines();
        tick();
        rst_n = 1'b1;
        tick();
        check_eq("rstmid.idle_busy", busy, 0);
        check_eq("rstmid.idle_en_update", en_update, 0);
        run_case("rst_rerun", 1, 0);

        // Start held through a run: next run begins right after HALT's IDLE.
        rand_plan();
        run_case("hold_a", 1, 1);
        run_case("hold_b", 0, 0);

        // Randomised runs.
        lat_rand = 1'b1;
        start_noise = 1'b1;
        for (int r = 0; r < 12; r++) begin
            rand_plan();
            n = $urandom_range(0, 2);
            for (int g = 0; g < n; g++) tick();
            run_case($sformatf("rand%0d", r), int'($urandom_range(0, 3)), 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

endmodule
